// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer: states, opcodes, alu_op
// bit positions, IR field positions and the opcode classifier.
package cpu_ctrl_pkg;

    localparam int unsigned IR_W      = 32;
    localparam int unsigned OP_LSB    = 27;
    localparam int unsigned RA_LSB    = 23;
    localparam int unsigned RB_LSB    = 19;
    localparam int unsigned RC_LSB    = 15;
    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned ALU_OP_W  = 13;
    localparam int unsigned ALU_IDX_W = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_e;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_SHR  = 5'b00101;
    localparam logic [4:0] OPC_SHRA = 5'b00110;
    localparam logic [4:0] OPC_SHL  = 5'b00111;
    localparam logic [4:0] OPC_ROR  = 5'b01000;
    localparam logic [4:0] OPC_ROL  = 5'b01001;
    localparam logic [4:0] OPC_AND  = 5'b01010;
    localparam logic [4:0] OPC_OR   = 5'b01011;
    localparam logic [4:0] OPC_MUL  = 5'b01111;
    localparam logic [4:0] OPC_DIV  = 5'b10000;
    localparam logic [4:0] OPC_NEG  = 5'b10001;
    localparam logic [4:0] OPC_NOT  = 5'b10010;

    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_MUL  = 2;
    localparam int unsigned ALU_DIV  = 3;
    localparam int unsigned ALU_AND  = 4;
    localparam int unsigned ALU_OR   = 5;
    localparam int unsigned ALU_SHR  = 6;
    localparam int unsigned ALU_SHRA = 7;
    localparam int unsigned ALU_SHL  = 8;
    localparam int unsigned ALU_ROR  = 9;
    localparam int unsigned ALU_ROL  = 10;
    localparam int unsigned ALU_NEG  = 11;
    localparam int unsigned ALU_NOT  = 12;

    typedef struct packed {
        logic                 legal;
        logic                 muldiv;
        logic                 unary;
        logic [ALU_IDX_W-1:0] alu_idx;
    } op_info_t;

    // Classify an opcode: legality, HI/LO result, single-source, alu_op bit.
    function automatic op_info_t decode_op(input logic [4:0] op);
        op_info_t info;
        info       = '0;
        info.legal = 1'b1;
        case (op)
            OPC_ADD:  info.alu_idx = ALU_IDX_W'(ALU_ADD);
            OPC_SUB:  info.alu_idx = ALU_IDX_W'(ALU_SUB);
            OPC_SHR:  info.alu_idx = ALU_IDX_W'(ALU_SHR);
            OPC_SHRA: info.alu_idx = ALU_IDX_W'(ALU_SHRA);
            OPC_SHL:  info.alu_idx = ALU_IDX_W'(ALU_SHL);
            OPC_ROR:  info.alu_idx = ALU_IDX_W'(ALU_ROR);
            OPC_ROL:  info.alu_idx = ALU_IDX_W'(ALU_ROL);
            OPC_AND:  info.alu_idx = ALU_IDX_W'(ALU_AND);
            OPC_OR:   info.alu_idx = ALU_IDX_W'(ALU_OR);
            OPC_MUL: begin
                info.alu_idx = ALU_IDX_W'(ALU_MUL);
                info.muldiv  = 1'b1;
            end
            OPC_DIV: begin
                info.alu_idx = ALU_IDX_W'(ALU_DIV);
                info.muldiv  = 1'b1;
            end
            OPC_NEG: begin
                info.alu_idx = ALU_IDX_W'(ALU_NEG);
                info.unary   = 1'b1;
            end
            OPC_NOT: begin
                info.alu_idx = ALU_IDX_W'(ALU_NOT);
                info.unary   = 1'b1;
            end
            default:  info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register index to one-hot select; indices at or beyond NUM_REGS select nothing.
module reg_select_decoder #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                en,
    input  logic [IDX_W-1:0]    idx,
    output logic [NUM_REGS-1:0] sel
);

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (en && (32'(idx) == i)) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_control_sequencer.sv
// Fetch/execute control sequencer for register-format ALU instructions.
// Build option ILLEGAL_TRAP_EN: illegal opcodes halt instead of executing as NOPs.
module alu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned OP_W     = 5
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [IR_W-1:0]     ir,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                MDMuxread,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zlowin,
    output logic                Zhighin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    state_e                 state;
    logic                   t1_first;
    logic [OP_W-1:0]        op_field;
    op_info_t               info;
    logic [REG_IDX_W-1:0]   ra;
    logic [REG_IDX_W-1:0]   rb;
    logic [REG_IDX_W-1:0]   rc;
    logic                   rin_en;
    logic                   rout_en;
    logic [REG_IDX_W-1:0]   rout_idx;
    logic                   unused_ir;

    assign op_field  = ir[OP_LSB +: OP_W];
    assign info      = decode_op(5'(op_field));
    assign ra        = ir[RA_LSB +: REG_IDX_W];
    assign rb        = ir[RB_LSB +: REG_IDX_W];
    assign rc        = ir[RC_LSB +: REG_IDX_W];
    assign unused_ir = ^ir[RC_LSB-1:0];

    // State register and transitions; t1_first marks the single PC write cycle.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= ST_IDLE;
            t1_first <= 1'b0;
        end else begin
            t1_first <= (state == ST_T0);
            case (state)
                ST_IDLE: if (run) state <= ST_T0;
                ST_T0:   state <= ST_T1;
                ST_T1:   if (mem_ready) state <= ST_T2;
                ST_T2:   state <= ST_T3;
                ST_T3: begin
                    if (info.legal) state <= ST_T4;
`ifdef ILLEGAL_TRAP_EN
                    else state <= ST_HALT;
`else
                    else state <= run ? ST_T0 : ST_IDLE;
`endif
                end
                ST_T4:   state <= ST_T5;
                ST_T5: begin
                    if (info.muldiv) state <= ST_T6;
                    else             state <= run ? ST_T0 : ST_IDLE;
                end
                ST_T6:   state <= run ? ST_T0 : ST_IDLE;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobe decode from the current step and the IR fields.
    always_comb begin
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        PCin      = 1'b0;
        MDMuxread = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zlowin    = 1'b0;
        Zhighin   = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        alu_op    = '0;
        done      = 1'b0;
        rin_en    = 1'b0;
        rout_en   = 1'b0;
        rout_idx  = rb;
        busy      = (state != ST_IDLE) && (state != ST_HALT);
        illegal   = (state == ST_HALT);
        case (state)
            ST_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            ST_T1: begin
                Zlowout   = t1_first;
                PCin      = t1_first;
                MDMuxread = 1'b1;
                MDRin     = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (info.legal) begin
                    rout_en = 1'b1;
                    Yin     = 1'b1;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    done = 1'b0;
`else
                    done = 1'b1;
`endif
                end
            end
            ST_T4: begin
                rout_en  = 1'b1;
                rout_idx = info.unary ? rb : rc;
                alu_op   = ALU_OP_W'(1) << info.alu_idx;
                Zlowin   = 1'b1;
                Zhighin  = info.muldiv;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                LOin    = info.muldiv;
                rin_en  = !info.muldiv;
                done    = !info.muldiv;
            end
            ST_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    reg_select_decoder #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (REG_IDX_W)
    ) u_rin_dec (
        .en  (rin_en),
        .idx (ra),
        .sel (Rin)
    );

    reg_select_decoder #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (REG_IDX_W)
    ) u_rout_dec (
        .en  (rout_en),
        .idx (rout_idx),
        .sel (Rout)
    );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer; outputs are sampled on the falling edge.
module tb_alu_control_sequencer;

    localparam logic [14:0] S_PCOUT    = 15'h4000;
    localparam logic [14:0] S_MARIN    = 15'h2000;
    localparam logic [14:0] S_INCPC    = 15'h1000;
    localparam logic [14:0] S_PCIN     = 15'h0800;
    localparam logic [14:0] S_MDMUX    = 15'h0400;
    localparam logic [14:0] S_MDRIN    = 15'h0200;
    localparam logic [14:0] S_MDROUT   = 15'h0100;
    localparam logic [14:0] S_IRIN     = 15'h0080;
    localparam logic [14:0] S_YIN      = 15'h0040;
    localparam logic [14:0] S_ZLOWIN   = 15'h0020;
    localparam logic [14:0] S_ZHIGHIN  = 15'h0010;
    localparam logic [14:0] S_ZLOWOUT  = 15'h0008;
    localparam logic [14:0] S_ZHIGHOUT = 15'h0004;
    localparam logic [14:0] S_HIIN     = 15'h0002;
    localparam logic [14:0] S_LOIN     = 15'h0001;

    localparam logic [12:0] A_ADD = 13'h0001;
    localparam logic [12:0] A_MUL = 13'h0004;
    localparam logic [12:0] A_ROL = 13'h0400;
    localparam logic [12:0] A_NEG = 13'h0800;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic [31:0] ir;
    logic        mem_ready;
    logic        PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin;
    logic        Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic [15:0] Rin, Rout;
    logic [12:0] alu_op;
    logic        busy, done, illegal;
    logic [14:0] strb_obs;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    assign strb_obs = {PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin,
                       Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin};

    alu_control_sequencer #(
        .NUM_REGS (16),
        .OP_W     (5)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .run       (run),
        .ir        (ir),
        .mem_ready (mem_ready),
        .PCout     (PCout),
        .MARin     (MARin),
        .IncPC     (IncPC),
        .PCin      (PCin),
        .MDMuxread (MDMuxread),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .IRin      (IRin),
        .Yin       (Yin),
        .Zlowin    (Zlowin),
        .Zhighin   (Zhighin),
        .Zlowout   (Zlowout),
        .Zhighout  (Zhighout),
        .HIin      (HIin),
        .LOin      (LOin),
        .Rin       (Rin),
        .Rout      (Rout),
        .alu_op    (alu_op),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [14:0] e_strb, input logic [15:0] e_rin,
                        input logic [15:0] e_rout, input logic [12:0] e_alu,
                        input logic e_done, input logic e_busy, input logic e_ill);
        chk({tag, ".strb"},    32'(strb_obs), 32'(e_strb));
        chk({tag, ".rin"},     32'(Rin),      32'(e_rin));
        chk({tag, ".rout"},    32'(Rout),     32'(e_rout));
        chk({tag, ".alu_op"},  32'(alu_op),   32'(e_alu));
        chk({tag, ".done"},    32'(done),     32'(e_done));
        chk({tag, ".busy"},    32'(busy),     32'(e_busy));
        chk({tag, ".illegal"}, 32'(illegal),  32'(e_ill));
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // T0..T2 with memory ready; run is set to keep_run once T0 is reached.
    task automatic fetch(input string tag, input logic keep_run);
        tick();
        step({tag, ".t0"}, S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        run = keep_run;
        tick();
        step({tag, ".t1"}, S_ZLOWOUT | S_PCIN | S_MDMUX | S_MDRIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        tick();
        step({tag, ".t2"}, S_MDROUT | S_IRIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, 1'b0);
    endtask

    // T3..T5 of ADD R1,R2,R3.
    task automatic add_tail(input string tag);
        tick();
        step({tag, ".t3"}, S_YIN, 16'h0, 16'h0004, 13'h0, 1'b0, 1'b1, 1'b0);
        tick();
        step({tag, ".t4"}, S_ZLOWIN, 16'h0, 16'h0008, A_ADD, 1'b0, 1'b1, 1'b0);
        tick();
        step({tag, ".t5"}, S_ZLOWOUT, 16'h0002, 16'h0, 13'h0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle_chk(input string tag);
        step(tag, 15'h0, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        clear     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b1;
        ir        = 32'h4891_8000;

        // Reset holds IDLE even across a clock edge with run high.
        #1 idle_chk("reset");
        tick();
        run = 1'b1;
        tick();
        idle_chk("reset_hold");
        run   = 1'b0;
        clear = 1'b1;
        tick();
        idle_chk("idle");

        // ROL R1,R2,R3 with a single run pulse.
        run = 1'b1;
        fetch("rol", 1'b0);
        tick();
        step("rol.t3", S_YIN, 16'h0, 16'h0004, 13'h0, 1'b0, 1'b1, 1'b0);
        tick();
        step("rol.t4", S_ZLOWIN, 16'h0, 16'h0008, A_ROL, 1'b0, 1'b1, 1'b0);
        tick();
        step("rol.t5", S_ZLOWOUT, 16'h0002, 16'h0, 13'h0, 1'b1, 1'b1, 1'b0);
        tick();
        idle_chk("rol.end");

        // MUL R4,R5,R6 uses HI/LO and a seventh step.
        ir  = {5'b01111, 4'd4, 4'd5, 4'd6, 15'd0};
        run = 1'b1;
        fetch("mul", 1'b0);
        tick();
        step("mul.t3", S_YIN, 16'h0, 16'h0020, 13'h0, 1'b0, 1'b1, 1'b0);
        tick();
        step("mul.t4", S_ZLOWIN | S_ZHIGHIN, 16'h0, 16'h0040, A_MUL, 1'b0, 1'b1, 1'b0);
        tick();
        step("mul.t5", S_ZLOWOUT | S_LOIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        tick();
        step("mul.t6", S_ZHIGHOUT | S_HIIN, 16'h0, 16'h0, 13'h0, 1'b1, 1'b1, 1'b0);
        tick();
        idle_chk("mul.end");

        // NEG R7,R9,R3: second source is Rb again, Rc ignored.
        ir  = {5'b10001, 4'd7, 4'd9, 4'd3, 15'd0};
        run = 1'b1;
        fetch("neg", 1'b0);
        tick();
        step("neg.t3", S_YIN, 16'h0, 16'h0200, 13'h0, 1'b0, 1'b1, 1'b0);
        tick();
        step("neg.t4", S_ZLOWIN, 16'h0, 16'h0200, A_NEG, 1'b0, 1'b1, 1'b0);
        tick();
        step("neg.t5", S_ZLOWOUT, 16'h0080, 16'h0, 13'h0, 1'b1, 1'b1, 1'b0);
        tick();
        idle_chk("neg.end");

        // ADD with memory stalled for three T1 cycles.
        ir        = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
        mem_ready = 1'b0;
        run       = 1'b1;
        tick();
        step("wait.t0", S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        run = 1'b0;
        tick();
        step("wait.t1a", S_ZLOWOUT | S_PCIN | S_MDMUX | S_MDRIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        tick();
        step("wait.t1b", S_MDMUX | S_MDRIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        tick();
        step("wait.t1c", S_MDMUX | S_MDRIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        tick();
        step("wait.t1d", S_MDMUX | S_MDRIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        mem_ready = 1'b1;
        tick();
        step("wait.t2", S_MDROUT | S_IRIN, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        add_tail("wait");
        tick();
        idle_chk("wait.end");

        // Two ADDs back to back; run drops mid-way through the second.
        run = 1'b1;
        fetch("b2b1", 1'b1);
        add_tail("b2b1");
        fetch("b2b2", 1'b1);
        run = 1'b0;
        add_tail("b2b2");
        tick();
        idle_chk("b2b.end");

        // Asynchronous clear in T4, then restart.
        run = 1'b1;
        fetch("clr", 1'b0);
        tick();
        step("clr.t3", S_YIN, 16'h0, 16'h0004, 13'h0, 1'b0, 1'b1, 1'b0);
        tick();
        step("clr.t4", S_ZLOWIN, 16'h0, 16'h0008, A_ADD, 1'b0, 1'b1, 1'b0);
        #2 clear = 1'b0;
        #1 idle_chk("clr.async");
        run = 1'b1;
        tick();
        idle_chk("clr.held");
        clear = 1'b1;
        fetch("clr_rs", 1'b0);
        add_tail("clr_rs");
        tick();
        idle_chk("clr_rs.end");

        // Illegal opcode 11111.
        ir  = {5'b11111, 4'd1, 4'd2, 4'd3, 15'd0};
        run = 1'b1;
        fetch("ill", 1'b0);
        tick();
`ifdef ILLEGAL_TRAP_EN
        step("ill.t3", 15'h0, 16'h0, 16'h0, 13'h0, 1'b0, 1'b1, 1'b0);
        tick();
        step("ill.halt", 15'h0, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b1);
        run = 1'b1;
        tick();
        tick();
        step("ill.stuck", 15'h0, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b1);
        run = 1'b0;
        #2 clear = 1'b0;
        #1 idle_chk("ill.clear");
        tick();
        clear = 1'b1;
        tick();
        idle_chk("ill.idle");
`else
        step("ill.t3", 15'h0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b1, 1'b0);
        tick();
        idle_chk("ill.idle");
        tick();
        idle_chk("ill.idle2");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach the end, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_control_sequencer.md
Name: alu_control_sequencer

Overview:
- Control unit that sits directly upstream of the Datapath. It generates, cycle by cycle, the one-hot control strobes that a bench otherwise drives by hand for the T0..T6 micro-steps.
- Covers the fetch steps (T0-T2) and execution of register-format ALU instructions, decoding opcode and register fields from the IR value the Datapath presents.
- Waits on a memory-ready handshake during fetch. Signals instruction completion to the surrounding system.

Parameters:
- NUM_REGS, 16, number of general registers; width of the Rin/Rout strobe vectors.
- OP_W, 5, opcode field width (ir[31:27]).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- clear  input  1  asynchronous, active-low reset.
- run  input  1  level; while high, the sequencer fetches and executes instructions back to back.
- ir  input  32  IR contents from the Datapath; ir[31:27]=op, ir[26:23]=Ra (dest), ir[22:19]=Rb, ir[18:15]=Rc.
- mem_ready  input  1  memory read data valid on Mdatain.
- PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin  output  1 each  Datapath strobes.
- Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin  output  1 each  Datapath strobes.
- Rin  output  NUM_REGS  one-hot register load strobes.
- Rout  output  NUM_REGS  one-hot register drive strobes.
- alu_op  output  13  one-hot, order ADD,SUB,MUL,DIV,AND,OR,SHR,SHRA,SHL,ROR,ROL,NEG,NOT.
- busy  output  1  high in any state other than IDLE or HALT.
- done  output  1  one-cycle pulse in the final step of each instruction.
- illegal  output  1  high while in HALT.

Behaviour:
- Outputs:
  - All outputs are a combinational decode of the registered state plus the ir fields.
  - Each strobe is asserted for the whole cycle of its step; the Datapath samples at the next rising edge.
  - Every strobe not listed for the current step is 0.
- Reset: clear low forces state IDLE immediately, including mid-instruction. All outputs read 0 while clear is low and in IDLE.
- Opcodes:
  - ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010.
  - All other opcodes are illegal.
- States and transitions:
  - IDLE: goes to T0 when run=1.
  - T0: PCout, MARin, IncPC, Zlowin. Goes to T1.
  - T1: Zlowout, PCin for the first T1 cycle only, so PC is written once. MDMuxread and MDRin are held every cycle. Stays in T1 while mem_ready=0; goes to T2 when mem_ready=1.
  - T2: MDRout, IRin. Goes to T3.
  - T3 (ir now valid): Rout[Rb], Yin. Goes to T4, or to HALT/T0 on an illegal opcode (see Optional Feature).
  - T4, binary ops: Rout[Rc], alu_op[op], Zlowin. MUL/DIV additionally assert Zhighin.
  - T4, unary ops (NEG/NOT): Rout[Rb], alu_op[op], Zlowin; Rc is ignored.
  - T5, non-MUL/DIV: Zlowout, Rin[Ra], done. Goes to T0 if run=1, else IDLE.
  - T5, MUL/DIV: Zlowout, LOin. Goes to T6.
  - T6 (MUL/DIV only): Zhighout, HIin, done. Goes to T0 if run=1, else IDLE.
  - HALT: illegal=1, all strobes 0. Leaves only via clear.
- run is sampled only in IDLE and in the final step. Dropping run mid-instruction does not abort the instruction.
- Register indices: Ra, Rb or Rc >= NUM_REGS produce no Rin/Rout bit (all zeros).
- Ra equal to Rb or Rc is legal, because the register write occurs only in T5.
- Latency: 6 cycles for non-MUL/DIV and 7 cycles for MUL/DIV with mem_ready high in T1; each extra T1 wait adds 1 cycle.
- done falls when the next T0 begins, so back-to-back instructions give exactly one done pulse per instruction.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an illegal opcode at T3 goes to HALT, with illegal=1 and no strobes.
- ILLEGAL_TRAP_EN undefined: an illegal opcode is a NOP. T3 asserts nothing and pulses done, then goes to T0 if run=1, else IDLE. illegal stays 0.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state enum (IDLE, T0-T6, HALT);
  - opcode constants;
  - alu_op bit-index constants;
  - ir field position constants.
- One sub-module, reg_select_decoder: 4-bit index plus enable gives a NUM_REGS one-hot vector. It is instantiated once for Rin and once for Rout.

Test Plan:
- ROL R1,R2,R3 (ir=0x48918000), mem_ready=1, run pulsed once:
  - T3: Rout=0x0004, Yin.
  - T4: Rout=0x0008, alu_op ROL, Zlowin.
  - T5: Rin=0x0002, done.
  - Then IDLE; 6 cycles total.
- MUL R4,R5,R6 (op 01111): T4 asserts Zlowin and Zhighin; T5 asserts LOin; T6 asserts HIin and done; 7 cycles total.
- mem_ready held 0 for 3 cycles in T1: T1 lasts 4 cycles, PCin is high only in the first, MDRin is high in all 4; total latency 9.
- run held 1 across two ADDs: one done pulse per instruction; T0 follows T5 with no IDLE cycle in between.
- clear pulsed low during T4: state IDLE and all outputs 0 immediately, without waiting for a clock edge; restart from T0 after clear rises and run=1.
- Opcode 11111:
  - with ILLEGAL_TRAP_EN, HALT and illegal=1, persisting until clear;
  - without it, done pulses at T3 and no Rin bit is ever set.
